paralelo_serial: RTL

Transmit end of the serial link: takes 8-bit parallel bytes and drives them onto a one-bit line, MSB first, one bit per `clk_32f` cycle. After reset it sends a run of COM symbols so the far-end `serial_paralelo` can lock. It then sends either data bytes or the IDLE symbol in every 8-cycle slot. It sits between the byte-level datapath and the serial wire, and the serial-to-parallel receiver is its loopback partner in the bench.

---
 rtl/paralelo_serial_pkg.sv | 13 +
 rtl/paralelo_serial_if.sv | 30 +++
 rtl/paralelo_serial_shift8.sv | 33 +++
 rtl/paralelo_serial.sv | 80 ++++++++
 4 files changed

// File: rtl/paralelo_serial_pkg.sv
// Shared constants and types for the serial link transmit/receive pair.
// The receiver uses the same COM/IDLE symbols to lock and to strip filler.
package ps_pkg;

    localparam logic [7:0] COM_SYMBOL  = 8'hBC;
    localparam logic [7:0] IDLE_SYMBOL = 8'h7C;

    typedef enum logic {
        SYNC,
        ACTIVE
    } ps_state_e;

endpackage

// File: rtl/paralelo_serial_if.sv
// Byte-side handshake and serial-side outputs of the transmitter.
// The master is the byte producer; the slave is paralelo_serial.
interface paralelo_serial_if;

    logic [7:0] data_in;
    logic       valid_in;
    logic       in_ready;
    logic       data_out;
    logic       sym_start;
    logic       active_out;

    modport master (
        output data_in,
        output valid_in,
        input  in_ready,
        input  data_out,
        input  sym_start,
        input  active_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output in_ready,
        output data_out,
        output sym_start,
        output active_out
    );

endinterface

// File: rtl/paralelo_serial_shift8.sv
// 8-bit MSB-first load/shift register with its bit counter.
// load is high on the last bit of a symbol, so the next edge loads a new one.
module ps_shift8 (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] next_sym,
    output logic       load,
    output logic       msb,
    output logic [2:0] bit_cnt
);

    logic [7:0] shreg_q;
    logic [2:0] bit_cnt_q;

    assign load    = (bit_cnt_q == 3'd7);
    assign msb     = shreg_q[7];
    assign bit_cnt = bit_cnt_q;

    // bit_cnt resets to 7 so the very first edge out of reset is a load edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q   <= '0;
            bit_cnt_q <= 3'd7;
        end else if (load) begin
            shreg_q   <= next_sym;
            bit_cnt_q <= 3'd0;
        end else begin
            shreg_q   <= {shreg_q[6:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 3'd1;
        end
    end

endmodule

// File: rtl/paralelo_serial.sv
// Parallel-to-serial transmitter: COM run after reset for receiver lock,
// then one data byte or IDLE per 8-cycle slot through a one-deep holding register.
module paralelo_serial
    import ps_pkg::*;
#(
    parameter int unsigned SYNC_COUNT  = 4,
    parameter logic [7:0]  COM_SYMBOL  = ps_pkg::COM_SYMBOL,
    parameter logic [7:0]  IDLE_SYMBOL = ps_pkg::IDLE_SYMBOL
) (
    input  logic               clk_32f,
    input  logic               reset,
    paralelo_serial_if.slave   bus
);

    localparam int unsigned SyncW = (SYNC_COUNT > 0) ? $clog2(SYNC_COUNT + 1) : 1;
    localparam logic [SyncW-1:0] SyncMax = SyncW'(SYNC_COUNT);

    ps_state_e        state_q;
    logic [SyncW-1:0] sync_cnt_q;
    logic [7:0]       hold_reg_q;
    logic             hold_valid_q;

    logic       load;
    logic       msb;
    logic [2:0] bit_cnt;
    logic [7:0] next_sym;
    logic       sync_phase;
    logic       in_ready;
    logic       xfer;

    assign sync_phase = (state_q == SYNC) && (sync_cnt_q < SyncMax);
    assign in_ready   = (state_q == ACTIVE) && !hold_valid_q;
    assign xfer       = bus.valid_in && in_ready;

    always_comb begin
        next_sym = IDLE_SYMBOL;
        if (sync_phase) begin
            next_sym = COM_SYMBOL;
        end else if (hold_valid_q) begin
            next_sym = hold_reg_q;
        end
    end

    // A byte accepted on a load edge lands in hold_reg; that slot stays IDLE.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q      <= SYNC;
            sync_cnt_q   <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            if (load) begin
                if (sync_phase) begin
                    sync_cnt_q <= sync_cnt_q + 1'b1;
                end else begin
                    state_q      <= ACTIVE;
                    hold_valid_q <= 1'b0;
                end
            end
            if (xfer) begin
                hold_reg_q   <= bus.data_in;
                hold_valid_q <= 1'b1;
            end
        end
    end

    ps_shift8 u_shift8 (
        .clk      (clk_32f),
        .reset    (reset),
        .next_sym (next_sym),
        .load     (load),
        .msb      (msb),
        .bit_cnt  (bit_cnt)
    );

    assign bus.data_out   = msb;
    assign bus.in_ready   = in_ready;
    assign bus.active_out = (state_q == ACTIVE);
    assign bus.sym_start  = (bit_cnt == 3'd0) && ((state_q == ACTIVE) || (sync_cnt_q != '0));

endmodule
